uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver, the counterpart of the team's 8N1 UART transmitter.
- Monitors the serial line, detects the start bit and samples each bit at mid-bit.
- Reassembles 8 data bits (LSB first), checks the stop bit, and presents a byte with a one-cycle valid strobe.
- Sits between the external RX pin and the pipeline's byte consumer; runs on the same bit timing as the transmitter.

Parameters:
- clocksPerBit, 87, clock cycles per serial bit. Legal range ≥4; must match the transmitter's value.

Ports:
- clkRx  input  1  receive clock; all logic on its rising edge
- rst  input  1  asynchronous, active-high reset
- serialIn  input  1  asynchronous serial line; idles high
- dataOutput  output  8  last correctly framed byte, held until the next good byte
- dataValid  output  1  one-cycle pulse when dataOutput is updated
- frameError  output  1  one-cycle pulse when the stop bit samples low

Behaviour:
- Reset (asynchronous, active-high):
  - dataOutput=0, dataValid=0, frameError=0.
  - State=idle; clkCount=0; bitIndex=0.
  - Synchronizer flops are preset to 1, so no false start on reset release.
  - Reset asserted mid-frame aborts the frame; no strobe is produced for that partial frame.
- Input synchronization:
  - serialIn passes through a 2-flop synchronizer; all decisions use the synchronized value rxSync.
- Counter widths:
  - clkCount width = $clog2(clocksPerBit); bitIndex is 3 bits.
  - All compares are against constants; no wrap-around of either counter.
- States and transitions:
  - idle:
    - clkCount=0, bitIndex=0.
    - When rxSync==0, go to startBit.
  - startBit:
    - Count to half = (clocksPerBit-1)/2 (43 at default).
    - At clkCount==half: if rxSync==0, clear clkCount and go to dataBits. Otherwise it was a glitch; return to idle with no output.
  - dataBits:
    - Count to clocksPerBit-1, then sample rxSync into shift[bitIndex] and clear clkCount.
    - After bitIndex 7 is sampled, clear bitIndex and go to stopBit.
  - stopBit:
    - At clkCount==clocksPerBit-1, sample rxSync.
    - If 1: load dataOutput with the shift register, pulse dataValid, go to idle.
    - If 0: pulse frameError, leave dataOutput unchanged, go to waitHigh.
  - waitHigh:
    - Stay until rxSync==1, then go to idle.
    - Prevents a held-low (break) line being taken as a new start bit.
- Timing:
  - Define E0 as the edge on which idle sees rxSync==0.
  - The start check is at E0+44; data bit k is sampled at E0+44+87·(k+1).
  - The stop bit is sampled at E0+827.
  - dataValid or frameError is high for exactly the one cycle after that edge.
  - From the raw serialIn falling edge, the strobe arrives 829–831 cycles later (synchronizer uncertainty).
- Back-to-back frames:
  - Returning to idle at mid-stop-bit gives half a bit of margin, so frames with zero idle gap are received.
- Simultaneous events:
  - dataValid and frameError are never high together.
  - The shift register is never visible on dataOutput except on a good stop bit.

Decomposition:
- Shared uart package:
  - state encoding constants idle/startBit/dataBits/stopBit/waitHigh (3-bit);
  - default clocksPerBit (87) for use by both transmitter and receiver;
  - data width constant 8.
- One natural sub-module, sync_2ff: 2-flop synchronizer with a reset-preset value parameter, reusable for other asynchronous inputs.

Test Plan:
- Single byte: drive 8N1 frame 0xA5 at 87 cycles/bit → dataValid one cycle, 829–831 cycles after the falling edge; dataOutput=0xA5; frameError stays 0.
- Back-to-back, zero gap: frames 0x00 then 0xFF → two dataValid pulses 870 cycles apart; dataOutput=0x00 then 0xFF.
- Glitch: serialIn low for 20 cycles, then high → no dataValid, no frameError; state returns to idle; a following 0x3C frame is received correctly.
- Framing error:
  - After a good 0x11, send 0x3C with the stop bit low and hold low for 300 cycles, then high → frameError pulses once; dataOutput stays 0x11; no spurious start while the line is low.
  - The next 0x7E frame is received as 0x7E.
- Reset mid-frame: assert rst during data bit 4 of 0xC3 → outputs go to 0 immediately; no strobe; after release, 0x81 is received correctly.
- Loopback with the team transmitter: send 0x5A, 0x00, 0xFF, 0x96 → received bytes match in order; no frameError.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: data width, default bit timing
// and receiver state encoding, used by both TX and RX.
package uart_rx_pkg;

  localparam int dataWidth           = 8;
  localparam int defaultClocksPerBit = 87;

  typedef enum logic [2:0] {
    idle     = 3'd0,
    startBit = 3'd1,
    dataBits = 3'd2,
    stopBit  = 3'd3,
    waitHigh = 3'd4
  } rxState_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input.
// Ports: clk, rst (async high), asyncIn -> syncOut; preset to resetValue.
module sync_2ff #(
  parameter logic resetValue = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic asyncIn,
  output logic syncOut
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta    <= resetValue;
      syncOut <= resetValue;
    end else begin
      meta    <= asyncIn;
      syncOut <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, mid-bit sampling, LSB first.
// Ports: clkRx, rst (async high), serialIn -> dataOutput, dataValid, frameError.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int clocksPerBit = defaultClocksPerBit
) (
  input  logic                 clkRx,
  input  logic                 rst,
  input  logic                 serialIn,
  output logic [dataWidth-1:0] dataOutput,
  output logic                 dataValid,
  output logic                 frameError
);

  localparam int cntW = $clog2(clocksPerBit);
  localparam logic [cntW-1:0] lastCnt =
    cntW'(clocksPerBit - 1);
  localparam logic [cntW-1:0] halfCnt =
    cntW'((clocksPerBit - 1) / 2);

  rxState_t             state;
  logic [cntW-1:0]      clkCount;
  logic [2:0]           bitIndex;
  logic [dataWidth-1:0] shiftReg;
  logic                 rxSync;

  // Preset high so reset release never looks like a start bit
  sync_2ff #(.resetValue(1'b1)) uSync (
    .clk     (clkRx),
    .rst     (rst),
    .asyncIn (serialIn),
    .syncOut (rxSync)
  );

  always_ff @(posedge clkRx or posedge rst) begin
    if (rst) begin
      state      <= idle;
      clkCount   <= '0;
      bitIndex   <= '0;
      shiftReg   <= '0;
      dataOutput <= '0;
      dataValid  <= 1'b0;
      frameError <= 1'b0;
    end else begin
      dataValid  <= 1'b0;
      frameError <= 1'b0;
      unique case (state)
        idle: begin
          clkCount <= '0;
          bitIndex <= '0;
          if (!rxSync) state <= startBit;
        end
        startBit: begin
          if (clkCount == halfCnt) begin
            clkCount <= '0;
            // High at mid-start means a glitch
            state    <= rxSync ? idle : dataBits;
          end else begin
            clkCount <= clkCount + 1'b1;
          end
        end
        dataBits: begin
          if (clkCount == lastCnt) begin
            clkCount           <= '0;
            shiftReg[bitIndex] <= rxSync;
            if (bitIndex == 3'd7) begin
              bitIndex <= '0;
              state    <= stopBit;
            end else begin
              bitIndex <= bitIndex + 3'd1;
            end
          end else begin
            clkCount <= clkCount + 1'b1;
          end
        end
        stopBit: begin
          if (clkCount == lastCnt) begin
            clkCount <= '0;
            // Leaving at mid-stop gives half a bit of
            // margin for a zero-gap next frame
            if (rxSync) begin
              dataOutput <= shiftReg;
              dataValid  <= 1'b1;
              state      <= idle;
            end else begin
              frameError <= 1'b1;
              state      <= waitHigh;
            end
          end else begin
            clkCount <= clkCount + 1'b1;
          end
        end
        waitHigh: begin
          // A break line must rise before a new start
          if (rxSync) state <= idle;
        end
        default: state <= idle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: behavioural 8N1 transmitter,
// scoreboard queue of expected bytes, monitor on negedge.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int cpb = 87;

  logic       clkRx = 1'b0;
  logic       rst = 1'b1;
  logic       serialIn = 1'b1;
  logic [7:0] dataOutput;
  logic       dataValid;
  logic       frameError;

  uart_rx #(.clocksPerBit(cpb)) dut (
    .clkRx      (clkRx),
    .rst        (rst),
    .serialIn   (serialIn),
    .dataOutput (dataOutput),
    .dataValid  (dataValid),
    .frameError (frameError)
  );

  always #5 clkRx = ~clkRx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int feCount = 0;
  int validCount = 0;
  int startCyc = 0;
  int validCyc[$];
  logic [7:0] expQ[$];

  always @(posedge clkRx) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clkRx) begin
    if (dataValid) begin
      validCount++;
      validCyc.push_back(cyc);
      check("valid/error overlap", frameError, 0);
      if (expQ.size() == 0)
        check("spurious dataValid", dataValid, 0);
      else
        check("rx byte", dataOutput, expQ.pop_front());
    end
    if (frameError) feCount++;
  end

  task automatic driveBit(input logic b, input int n);
    serialIn = b;
    repeat (n) @(negedge clkRx);
  endtask

  task automatic sendByte(input logic [7:0] b);
    expQ.push_back(b);
    driveBit(1'b0, cpb);
    for (int i = 0; i < 8; i++) driveBit(b[i], cpb);
    driveBit(1'b1, cpb);
  endtask

  initial begin
    logic [7:0] lb[4];
    lb[0] = 8'h5A; lb[1] = 8'h00;
    lb[2] = 8'hFF; lb[3] = 8'h96;

    repeat (3) @(negedge clkRx);
    check("reset dataOutput", dataOutput, 0);
    check("reset dataValid", dataValid, 0);
    check("reset frameError", frameError, 0);
    rst = 1'b0;
    repeat (10) @(negedge clkRx);
    check("idle after reset", dut.state, idle);

    // single byte with latency
    startCyc = cyc;
    sendByte(8'hA5);
    repeat (20) @(negedge clkRx);
    check("valid count A5", validCount, 1);
    if (validCyc.size() > 0)
      check("latency", validCyc[0] - startCyc, 830);

    // zero-gap back-to-back
    sendByte(8'h00);
    sendByte(8'hFF);
    repeat (20) @(negedge clkRx);
    check("valid count b2b", validCount, 3);
    if (validCyc.size() > 2)
      check("b2b spacing",
            validCyc[2] - validCyc[1], 870);

    // glitch on line
    driveBit(1'b0, 20);
    driveBit(1'b1, 100);
    check("glitch state", dut.state, idle);
    check("glitch no valid", validCount, 3);
    check("glitch no ferr", feCount, 0);
    sendByte(8'h3C);

    // framing error with held-low line
    sendByte(8'h11);
    driveBit(1'b0, cpb);
    for (int i = 0; i < 8; i++)
      driveBit(((8'h3C >> i) & 8'h1) != 0, cpb);
    driveBit(1'b0, 300);
    check("break waitHigh", dut.state, waitHigh);
    driveBit(1'b1, 2 * cpb);
    check("ferr count", feCount, 1);
    check("ferr keeps data", dataOutput, 8'h11);
    check("ferr no valid", validCount, 5);
    sendByte(8'h7E);
    repeat (20) @(negedge clkRx);
    check("after ferr byte", dataOutput, 8'h7E);

    // reset during data bit 4 of 0xC3
    driveBit(1'b0, cpb);
    for (int i = 0; i < 4; i++)
      driveBit(((8'hC3 >> i) & 8'h1) != 0, cpb);
    driveBit(1'b0, 40);
    rst = 1'b1;
    #1;
    check("midrst dataOutput", dataOutput, 0);
    check("midrst dataValid", dataValid, 0);
    check("midrst state", dut.state, idle);
    serialIn = 1'b1;
    repeat (5) @(negedge clkRx);
    rst = 1'b0;
    repeat (2 * cpb) @(negedge clkRx);
    check("midrst no valid", validCount, 6);
    sendByte(8'h81);

    // loopback burst
    for (int i = 0; i < 4; i++) sendByte(lb[i]);
    repeat (200) @(negedge clkRx);

    check("queue drained", expQ.size(), 0);
    check("total valid", validCount, 11);
    check("total ferr", feCount, 1);
    check("final byte", dataOutput, 8'h96);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
